// File: rtl/pdm_pkg.sv
// Shared constants for the PDM microphone capture path.
package pdm_pkg;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_STEREO = 2'b10;

  // Width of the system-clock divider counter for a given half-period.
  function automatic int div_cnt_w(input int clk_div);
    return (clk_div < 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM clock divider: toggles clock_pdm every CLK_DIV system clocks and
// flags the terminal-count cycle of each phase as a capture strobe.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic clock_pdm,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = div_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc       = enable && (cnt == TC);
  // Strobes name the edge clock_pdm is about to take at this cycle's end.
  assign rise_stb = tc & ~clock_pdm;
  assign fall_stb = tc & clock_pdm;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      clock_pdm <= 1'b0;
    end else if (!enable) begin
      cnt       <= '0;
      clock_pdm <= 1'b0;
    end else if (tc) begin
      cnt       <= '0;
      clock_pdm <= ~clock_pdm;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM mic front end: samples L/R mics on opposite clock phases, packs
// WORD_W bits per channel MSB first, and holds words for a valid/ready sink.
module pdm_mic_capture
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int WORD_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              mic_in_pdm,
  output logic              clock_pdm,
  output logic              sel_LR,
  output logic [WORD_W-1:0] out_left,
  output logic [WORD_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int BCW = (WORD_W < 2) ? 1 : $clog2(WORD_W);

  logic                   rise_stb, fall_stb;
  logic                   start;
  logic [1:0]             mode_q;
  logic [1:0]             ch_en, cap;
  logic [1:0][WORD_W-1:0] sr, sr_nxt;
  logic [BCW-1:0]         bit_cnt;
  logic                   cnt_ev, done, load, drop;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clock_pdm (clock_pdm),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb)
  );

  // Channel 0 = left (end of high phase), channel 1 = right (end of low phase).
  assign ch_en[0] = (mode_q != MODE_RIGHT);
  assign ch_en[1] = (mode_q != MODE_LEFT);
  assign cap[0]   = fall_stb & ch_en[0];
  assign cap[1]   = rise_stb & ~start & ch_en[1];

  always_comb begin
    sr_nxt = sr;
    for (int ch = 0; ch < 2; ch++)
      if (cap[ch]) sr_nxt[ch] = {sr[ch][WORD_W-2:0], mic_in_pdm};
  end

  // Right channel captures last in each L/R pair, so it paces stereo words.
  assign cnt_ev = ch_en[1] ? cap[1] : cap[0];
  assign done   = cnt_ev && (bit_cnt == BCW'(WORD_W - 1));
  assign load   = done && (!out_valid || out_ready);
  assign drop   = done && out_valid && !out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_LEFT;
      sel_LR  <= 1'b0;
      start   <= 1'b1;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      sel_LR <= (mode_q == MODE_RIGHT);
      if (!enable) begin
        mode_q  <= (mode == MODE_RIGHT || mode == MODE_STEREO) ? mode : MODE_LEFT;
        start   <= 1'b1;
        bit_cnt <= '0;
        sr      <= '0;
      end else begin
        sr <= sr_nxt;
        if (rise_stb) start <= 1'b0;
        if (done)        bit_cnt <= '0;
        else if (cnt_ev) bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_left  <= ch_en[0] ? sr_nxt[0] : '0;
        out_right <= ch_en[1] ? sr_nxt[1] : '0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Bench for pdm_mic_capture: per-cycle mic bit table, capture instants and
// expected words derived arithmetically from the PDM timing rules.
module tb_pdm_mic_capture;

  localparam int CD = 4;
  localparam int W  = 8;
  localparam int P  = 2 * CD * W;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [1:0]   mode;
  logic         mic_in_pdm;
  logic         clock_pdm;
  logic         sel_LR;
  logic [W-1:0] out_left, out_right;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;
  logic         clear_ovf;

  int tests = 0;
  int fails = 0;
  bit bits [0:1023];

  always #5 clock = ~clock;

  pdm_mic_capture #(.CLK_DIV(CD), .WORD_W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .mic_in_pdm (mic_in_pdm),
    .clock_pdm  (clock_pdm),
    .sel_LR     (sel_LR),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  // Edge k counts posedges since enable rose (k=0 is the first enabled edge).
  // L bit j is sampled at edge 2*CD*(j+1)-1; R bit j one half-period later
  // (the very first rising toggle, at edge CD-1, is skipped).
  function automatic logic [W-1:0] exp_word(input bit right, input int n);
    logic [W-1:0] w;
    int j, k;
    for (int b = 0; b < W; b++) begin
      j = n * W + b;
      k = right ? 2 * CD * (j + 1) + CD - 1 : 2 * CD * (j + 1) - 1;
      w[W-1-b] = bits[k];
    end
    return w;
  endfunction

  task automatic fill_bits(input int pat, input int n);
    for (int k = 0; k < n; k++)
      case (pat)
        1:       bits[k] = 1'b1;
        2:       bits[k] = ((k / (2 * CD)) % 2) == 0;
        3:       bits[k] = ((k / CD) % 2) == 1;
        default: bits[k] = 1'($urandom);
      endcase
  endtask

  task automatic idle_mode(input logic [1:0] m);
    @(negedge clock);
    enable = 1'b0;
    mode   = m;
    repeat (3) @(negedge clock);
  endtask

  task automatic run_capture(input logic [1:0] m, input int nwords, input int pat);
    int n, e, offs, nc;
    bit exp_v, right_paced;
    logic [W-1:0] el, er;
    out_ready = 1'b1;
    idle_mode(m);
    tests++;
    if (sel_LR !== (m == 2'b01)) begin
      fails++;
      $display("FAIL sel_LR mode=%0d got=%b exp=%b", m, sel_LR, (m == 2'b01));
    end
    nc = nwords * P + 2 * CD + 2;
    fill_bits(pat, nc);
    right_paced = (m == 2'b01) || (m == 2'b10);
    offs = right_paced ? CD - 1 : -1;
    for (int k = 0; k < nc; k++) begin
      @(negedge clock);
      if (k > 0) begin
        e = k - 1;
        tests++;
        if (clock_pdm !== 1'((k / CD) % 2)) begin
          fails++;
          $display("FAIL clock_pdm mode=%0d k=%0d got=%b exp=%b", m, k, clock_pdm, 1'((k / CD) % 2));
        end
        exp_v = (e - offs) >= P && ((e - offs) % P) == 0;
        tests++;
        if (out_valid !== exp_v) begin
          fails++;
          $display("FAIL out_valid mode=%0d edge=%0d got=%b exp=%b", m, e, out_valid, exp_v);
        end
        if (exp_v) begin
          n  = (e - offs) / P - 1;
          el = (m == 2'b01) ? '0 : exp_word(1'b0, n);
          er = right_paced  ? exp_word(1'b1, n) : '0;
          tests++;
          if (out_left !== el || out_right !== er) begin
            fails++;
            $display("FAIL word mode=%0d n=%0d got=%h/%h exp=%h/%h", m, n, out_left, out_right, el, er);
          end
        end
      end
      mic_in_pdm = bits[k];
      if (k == 0) enable = 1'b1;
    end
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({clock_pdm, sel_LR, out_left, out_right, out_valid, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state got=%b%b %h %h %b%b exp=all 0", clock_pdm, sel_LR,
               out_left, out_right, out_valid, overflow);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_backpressure;
    logic [W-1:0] w0;
    idle_mode(2'b00);
    out_ready = 1'b0;
    fill_bits(0, 2 * P + 2);
    w0 = exp_word(1'b0, 0);
    for (int k = 0; k <= 2 * P; k++) begin
      @(negedge clock);
      if (k == P || k == P + 36 || k == 2 * P) begin
        tests++;
        if (out_valid !== 1'b1 || out_left !== w0 || out_right !== '0) begin
          fails++;
          $display("FAIL bp_hold k=%0d got=%b %h %h exp=1 %h 00", k, out_valid, out_left, out_right, w0);
        end
        tests++;
        if (overflow !== (k == 2 * P)) begin
          fails++;
          $display("FAIL bp_overflow k=%0d got=%b exp=%b", k, overflow, (k == 2 * P));
        end
      end
      if (k == 2 * P) enable = 1'b0;
      else mic_in_pdm = bits[k];
      if (k == 0) enable = 1'b1;
    end
    clear_ovf = 1'b1;
    @(negedge clock);
    clear_ovf = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL clear_ovf got=%b exp=0", overflow);
    end
    tests++;
    if (out_valid !== 1'b1 || out_left !== w0) begin
      fails++;
      $display("FAIL bp_idle_hold got=%b %h exp=1 %h", out_valid, out_left, w0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_abort;
    idle_mode(2'b00);
    for (int k = 0; k < 26; k++) begin
      @(negedge clock);
      mic_in_pdm = 1'($urandom);
      if (k == 0) enable = 1'b1;
    end
    @(negedge clock);
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      tests++;
      if (clock_pdm !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_idle i=%0d clock_pdm=%b out_valid=%b exp=0 0", i, clock_pdm, out_valid);
      end
    end
    run_capture(2'b00, 1, 0);
  endtask

  task automatic test_async_reset;
    idle_mode(2'b00);
    out_ready = 1'b0;
    for (int k = 0; k <= P; k++) begin
      @(negedge clock);
      mic_in_pdm = 1'($urandom);
      if (k == 0) enable = 1'b1;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid got=%b exp=1", out_valid);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({clock_pdm, sel_LR, out_left, out_right, out_valid, overflow} !== '0) begin
      fails++;
      $display("FAIL async_reset got=%b%b %h %h %b%b exp=all 0", clock_pdm, sel_LR,
               out_left, out_right, out_valid, overflow);
    end
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run_capture(2'b01, 2, 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 2'b00; mic_in_pdm = 1'b0;
    out_ready = 1'b1; clear_ovf = 1'b0;
    #12;
    test_reset;
    run_capture(2'b00, 2, 1);   // constant 1 -> FF
    run_capture(2'b00, 2, 2);   // alternating L bits -> AA
    run_capture(2'b10, 2, 3);   // stereo L=1, R=0
    run_capture(2'b10, 2, 0);   // stereo random
    run_capture(2'b11, 1, 0);   // mode 11 behaves as mono-left
    test_backpressure;
    test_abort;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
